// File: rtl/trip_timer_pkg.sv
// trip_timer_pkg
//   Shared types and constants for the trip timer: controller state
//   encoding, H:M:S field widths and rollover limits, and the packed
//   H:M:S record that appears on the trip_time output.
package trip_timer_pkg;

  localparam int HRS_W    = 7;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 7;
  localparam int HMS_W    = 20;
  localparam int HS_CUM_W = 19;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  // Encodings are visible on the state port and read by the display logic.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_RUNNING     = 2'd1,
    ST_AUTO_PAUSED = 2'd2,
    ST_STOPPED     = 2'd3
  } trip_state_e;

  // Field order matches trip_time: {hrs[19:13], min[12:7], sec[6:0]}.
  typedef struct packed {
    logic [HRS_W-1:0] hrs;
    logic [MIN_W-1:0] mins;
    logic [SEC_W-1:0] secs;
  } hms_t;

endpackage

// File: rtl/hms_counter.sv
// hms_counter
//   Saturating hours:minutes:seconds counter. Each cycle with inc high
//   advances the time by one second, carrying sec -> min -> hrs in the
//   same cycle. At MAX_HRS:59:59 a further increment leaves the time
//   unchanged and sets the sticky sat flag.
//
//   Ports:
//     clock  in   system clock
//     reset  in   synchronous, active-high reset
//     clear  in   synchronous clear of time and sat (beats inc)
//     inc    in   advance by one second
//     hms    out  packed {hrs, min, sec}, registered
//     sat    out  sticky saturation flag, registered
module hms_counter
  import trip_timer_pkg::*;
#(
  parameter int MAX_HRS = 99
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [HMS_W-1:0] hms,
  output logic             sat
);

  hms_t hms_q, hms_d;
  logic sat_q, sat_d;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hms_d = hms_q;
    sat_d = sat_q;
    if (clear) begin
      hms_d = '0;
      sat_d = 1'b0;
    end else if (inc) begin
      if (hms_q.secs != SEC_W'(SEC_MAX)) begin
        hms_d.secs = hms_q.secs + 1'b1;
      end else if (hms_q.mins != MIN_W'(MIN_MAX)) begin
        hms_d.secs = '0;
        hms_d.mins = hms_q.mins + 1'b1;
      end else if (hms_q.hrs != HRS_W'(MAX_HRS)) begin
        hms_d.secs = '0;
        hms_d.mins = '0;
        hms_d.hrs  = hms_q.hrs + 1'b1;
      end else begin
        sat_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      hms_q <= '0;
      sat_q <= 1'b0;
    end else begin
      hms_q <= hms_d;
      sat_q <= sat_d;
    end
  end

  assign hms = hms_q;
  assign sat = sat_q;

endmodule

// File: rtl/trip_timer_ctrl.sv
// trip_timer_ctrl
//   Bike-computer trip stopwatch. Decides when elapsed ride time
//   accumulates: half-second ticks count only while RUNNING, every second
//   counted tick advances the H:M:S trip time, and a cumulative half-second
//   count feeds the average-speed calculation.
//
//   Optional feature macro: TRIP_AUTO_PAUSE_EN. When defined, an idle
//   counter pauses the timer after AUTO_PAUSE_HS ticks without a wheel
//   motion pulse, and motion resumes it. When undefined, AUTO_PAUSED is
//   never entered and motion_pulse is ignored.
//
//   Ports:
//     clock           in   system clock
//     reset           in   synchronous, active-high reset
//     half_sec_pulse  in   one-cycle tick from the timebase
//     start_stop      in   one-cycle start/stop button event
//     clear           in   one-cycle clear button event
//     motion_pulse    in   one-cycle wheel-sensor event
//     trip_time       out  {hrs[19:13], min[12:7], sec[6:0]}
//     trip_half_sec   out  cumulative half-seconds spent RUNNING (saturating)
//     state           out  0=IDLE 1=RUNNING 2=AUTO_PAUSED 3=STOPPED
//     running         out  high when state is RUNNING
//     overflow        out  sticky, set when trip_time saturates
module trip_timer_ctrl
  import trip_timer_pkg::*;
#(
  parameter int AUTO_PAUSE_HS = 6,
  parameter int MAX_HRS       = 99
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                half_sec_pulse,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                motion_pulse,
  output logic [HMS_W-1:0]    trip_time,
  output logic [HS_CUM_W-1:0] trip_half_sec,
  output logic [1:0]          state,
  output logic                running,
  output logic                overflow
);

  if (AUTO_PAUSE_HS < 1 || AUTO_PAUSE_HS > 255) begin : g_bad_auto_pause
    $error("AUTO_PAUSE_HS must be in 1..255");
  end

  trip_state_e         state_q, state_d;
  logic                phase_q, phase_d;
  logic [HS_CUM_W-1:0] half_q, half_d;
  logic                running_q, running_d;
  logic                count_hs;
  logic                inc_sec;

`ifdef TRIP_AUTO_PAUSE_EN
  localparam logic [7:0] AP_LIMIT = 8'(AUTO_PAUSE_HS);
  logic [7:0] idle_q, idle_d;
  logic [7:0] idle_inc;
  assign idle_inc = idle_q + 8'd1;
`else
  // Without auto-pause nothing consumes wheel motion.
  logic unused_motion;
  assign unused_motion = motion_pulse;
`endif

  // Ticks count against the pre-transition state, so a tick coinciding
  // with start_stop in RUNNING still counts.
  assign count_hs = half_sec_pulse && (state_q == ST_RUNNING);
  // A second elapses on the phase 1->0 toggle.
  assign inc_sec  = count_hs && phase_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    half_d  = half_q;
`ifdef TRIP_AUTO_PAUSE_EN
    idle_d  = idle_q;
`endif
    if (clear) begin
      state_d = ST_IDLE;
      phase_d = 1'b0;
      half_d  = '0;
`ifdef TRIP_AUTO_PAUSE_EN
      idle_d  = '0;
`endif
    end else begin
      if (count_hs) begin
        if (half_q != '1) half_d = half_q + 1'b1;
        phase_d = ~phase_q;
      end
      unique case (state_q)
        ST_IDLE, ST_STOPPED: begin
          if (start_stop) begin
            state_d = ST_RUNNING;
`ifdef TRIP_AUTO_PAUSE_EN
            idle_d  = '0;
`endif
          end
        end
        ST_RUNNING: begin
          if (start_stop) begin
            state_d = ST_STOPPED;
          end
`ifdef TRIP_AUTO_PAUSE_EN
          // Motion beats a same-cycle tick; the tick reaching the limit
          // is itself counted above.
          else if (motion_pulse) begin
            idle_d = '0;
          end else if (half_sec_pulse) begin
            idle_d = idle_inc;
            if (idle_inc == AP_LIMIT) state_d = ST_AUTO_PAUSED;
          end
`endif
        end
        ST_AUTO_PAUSED: begin
          if (start_stop) begin
            state_d = ST_STOPPED;
          end
`ifdef TRIP_AUTO_PAUSE_EN
          else if (motion_pulse) begin
            state_d = ST_RUNNING;
            idle_d  = '0;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      half_q    <= '0;
      running_q <= 1'b0;
`ifdef TRIP_AUTO_PAUSE_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      half_q    <= half_d;
      running_q <= running_d;
`ifdef TRIP_AUTO_PAUSE_EN
      idle_q    <= idle_d;
`endif
    end
  end

  hms_counter #(
    .MAX_HRS(MAX_HRS)
  ) u_hms (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (inc_sec),
    .hms   (trip_time),
    .sat   (overflow)
  );

  assign trip_half_sec = half_q;
  assign state         = state_q;
  assign running       = running_q;

endmodule

// File: tb/tb_trip_timer_ctrl.sv
// tb_trip_timer_ctrl
//   Directed and randomized stimulus for two trip_timer_ctrl instances
//   (default parameters, and MAX_HRS=1 / AUTO_PAUSE_HS=3), each compared
//   every cycle against a behavioural model that tracks elapsed seconds
//   as a plain integer. Honours TRIP_AUTO_PAUSE_EN like the design.
module tb_trip_timer_ctrl;
  import trip_timer_pkg::*;

`ifdef TRIP_AUTO_PAUSE_EN
  localparam bit AP_EN = 1'b1;
`else
  localparam bit AP_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic hp = 1'b0, ss = 1'b0, clr = 1'b0, mp = 1'b0;

  logic [19:0] tt_a, tt_b;
  logic [18:0] hs_a, hs_b;
  logic [1:0]  st_a, st_b;
  logic        run_a, run_b, ov_a, ov_b;

  always #5 clock = ~clock;

  trip_timer_ctrl dut_a (
    .clock(clock), .reset(reset), .half_sec_pulse(hp), .start_stop(ss),
    .clear(clr), .motion_pulse(mp), .trip_time(tt_a), .trip_half_sec(hs_a),
    .state(st_a), .running(run_a), .overflow(ov_a)
  );

  trip_timer_ctrl #(.AUTO_PAUSE_HS(3), .MAX_HRS(1)) dut_b (
    .clock(clock), .reset(reset), .half_sec_pulse(hp), .start_stop(ss),
    .clear(clr), .motion_pulse(mp), .trip_time(tt_b), .trip_half_sec(hs_b),
    .state(st_b), .running(run_b), .overflow(ov_b)
  );

  // Model: st 0..3, half = counted ticks, secs = elapsed whole seconds.
  typedef struct {
    int st;
    int half;
    bit phase;
    int idle;
    int secs;
    bit ovf;
  } model_t;

  model_t ma, mb;
  int tests = 0;
  int fails = 0;

  function automatic model_t model_step(model_t m, int max_hrs, int ap,
                                        bit zap, bit s, bit h, bit mo);
    model_t n = m;
    int cap = max_hrs * 3600 + 3599;
    if (zap) begin
      n = '{default: 0};
      return n;
    end
    if (h && m.st == 1) begin
      if (m.half < 524287) n.half = m.half + 1;
      if (m.phase) begin
        if (m.secs == cap) n.ovf = 1'b1;
        else n.secs = m.secs + 1;
      end
      n.phase = !m.phase;
    end
    case (m.st)
      0, 3: if (s) begin n.st = 1; n.idle = 0; end
      1: begin
        if (s) n.st = 3;
        else if (AP_EN) begin
          if (mo) n.idle = 0;
          else if (h) begin
            n.idle = m.idle + 1;
            if (n.idle == ap) n.st = 2;
          end
        end
      end
      2: begin
        if (s) n.st = 3;
        else if (AP_EN && mo) begin n.st = 1; n.idle = 0; end
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] pack_hms(int secs);
    int h = secs / 3600;
    int mi = (secs % 3600) / 60;
    int s = secs % 60;
    return 32'({7'(h), 6'(mi), 7'(s)});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("a.trip_time",     32'(tt_a),  pack_hms(ma.secs));
    check("a.trip_half_sec", 32'(hs_a),  32'(ma.half));
    check("a.state",         32'(st_a),  32'(ma.st));
    check("a.running",       32'(run_a), 32'(ma.st == 1));
    check("a.overflow",      32'(ov_a),  32'(ma.ovf));
    check("b.trip_time",     32'(tt_b),  pack_hms(mb.secs));
    check("b.trip_half_sec", 32'(hs_b),  32'(mb.half));
    check("b.state",         32'(st_b),  32'(mb.st));
    check("b.running",       32'(run_b), 32'(mb.st == 1));
    check("b.overflow",      32'(ov_b),  32'(mb.ovf));
  endtask

  // One clock: drive inputs, advance both models on the edge, sample #1 later.
  task automatic cyc(input bit s, input bit c, input bit h, input bit m,
                     input bit r = 1'b0);
    ss = s; clr = c; hp = h; mp = m; reset = r;
    @(posedge clock);
    ma = model_step(ma, 99, 6, r || c, s, h, m);
    mb = model_step(mb, 1, 3, r || c, s, h, m);
    #1;
    ss = 1'b0; clr = 1'b0; hp = 1'b0; mp = 1'b0; reset = 1'b0;
    compare_all();
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset state.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("reset state", 32'(st_a), 32'd0);
    check("reset trip_time", 32'(tt_a), 32'd0);

    // Start, ten ticks (motion keeps auto-pause away) -> 0:0:5.
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 1, 1);
    check("t1 trip_time", 32'(tt_a), 32'({7'd0, 6'd0, 7'd5}));
    check("t1 half_sec",  32'(hs_a), 32'd10);
    check("t1 state",     32'(st_a), 32'd1);

    // Seconds carry into minutes, then minutes into hours.
    repeat (109) cyc(0, 0, 1, 1);
    check("t2 0:0:59", 32'(tt_a), 32'({7'd0, 6'd0, 7'd59}));
    cyc(0, 0, 1, 1);
    check("t2 0:1:0", 32'(tt_a), 32'({7'd0, 6'd1, 7'd0}));
    repeat (7079) cyc(0, 0, 1, 1);
    check("t2 0:59:59", 32'(tt_a), 32'({7'd0, 6'd59, 7'd59}));
    cyc(0, 0, 1, 1);
    check("t2 1:0:0 a", 32'(tt_a), 32'({7'd1, 6'd0, 7'd0}));
    check("t2 1:0:0 b", 32'(tt_b), 32'({7'd1, 6'd0, 7'd0}));

    // start_stop with a tick: counted from RUNNING, not from STOPPED.
    cyc(1, 0, 1, 0);
    check("t3 run->stop half", 32'(hs_a), 32'd7201);
    check("t3 run->stop state", 32'(st_a), 32'd3);
    cyc(1, 0, 1, 0);
    check("t3 stop->run half", 32'(hs_a), 32'd7201);
    check("t3 stop->run state", 32'(st_a), 32'd1);

    if (AP_EN) begin
      repeat (5) cyc(0, 0, 1, 0);
      check("t4 five idle ticks", 32'(st_a), 32'd1);
      cyc(0, 0, 1, 0);
      check("t4 pause half", 32'(hs_a), 32'd7207);
      check("t4 pause state", 32'(st_a), 32'd2);
      repeat (3) cyc(0, 0, 1, 0);
      check("t4 paused hold", 32'(hs_a), 32'd7207);
      cyc(0, 0, 0, 1);
      check("t4 motion resume", 32'(st_a), 32'd1);
      cyc(0, 0, 1, 1);
      repeat (5) cyc(0, 0, 1, 0);
      check("t4 motion beat tick", 32'(st_a), 32'd1);
      cyc(0, 0, 1, 0);
      check("t4 repause", 32'(st_a), 32'd2);
      check("t4 repause half", 32'(hs_a), 32'd7214);
    end else begin
      repeat (8) cyc(0, 0, 1, 0);
      check("t4 no auto-pause", 32'(st_a), 32'd1);
      check("t4 half", 32'(hs_a), 32'd7209);
      cyc(0, 0, 0, 1);
      check("t4 motion ignored", 32'(st_a), 32'd1);
    end

    // Saturation on the MAX_HRS=1 instance.
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (14399) cyc(0, 0, 1, 1);
    check("t5 1:59:59", 32'(tt_b), 32'({7'd1, 6'd59, 7'd59}));
    check("t5 no ovf yet", 32'(ov_b), 32'd0);
    cyc(0, 0, 1, 1);
    check("t5 hold", 32'(tt_b), 32'({7'd1, 6'd59, 7'd59}));
    check("t5 overflow", 32'(ov_b), 32'd1);
    check("t5 half keeps counting", 32'(hs_b), 32'd14400);
    check("t5 a 2:0:0", 32'(tt_a), 32'({7'd2, 6'd0, 7'd0}));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 16) == 0, ($urandom % 64) == 0, ($urandom % 3) == 0,
          ($urandom % 4) == 0, ($urandom % 250) == 0);
    end

    // clear together with start_stop mid-RUNNING.
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (7) cyc(0, 0, 1, 1);
    cyc(1, 1, 1, 1);
    check("t7 state", 32'(st_a), 32'd0);
    check("t7 trip_time", 32'(tt_a), 32'd0);
    check("t7 half", 32'(hs_a), 32'd0);
    check("t7 running", 32'(run_a), 32'd0);
    check("t7 overflow b", 32'(ov_b), 32'd0);

    // reset mid-count.
    cyc(1, 0, 0, 0);
    repeat (9) cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1, 1);
    check("t8 state", 32'(st_a), 32'd0);
    check("t8 trip_time", 32'(tt_a), 32'd0);
    check("t8 half", 32'(hs_a), 32'd0);
    check("t8 running", 32'(run_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trip_timer_ctrl.md
Name: trip_timer_ctrl

Overview:
- Stopwatch/trip-time controller for the bike computer; it sequences when elapsed ride time accumulates.
- It consumes the half-second tick from the free-running timebase, the rider's start/stop and clear button events, and wheel-sensor motion pulses.
- It produces a gated H:M:S trip time, a cumulative running half-second count for average-speed calculation, and the controller state for the display logic.

Parameters:
- AUTO_PAUSE_HS, 6, half-second ticks without a motion pulse before auto-pause (legal range 1..255).
- MAX_HRS, 99, hour value at which the trip time saturates.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- half_sec_pulse  in  1  one-cycle tick from the timebase, once per 1024 clocks
- start_stop  in  1  one-cycle debounced button event
- clear  in  1  one-cycle debounced button event
- motion_pulse  in  1  one-cycle wheel-sensor event
- trip_time  out  20  {hrs[19:13], min[12:7], sec[6:0]}, binary fields
- trip_half_sec  out  19  cumulative half-seconds spent in RUNNING
- state  out  2  0=IDLE, 1=RUNNING, 2=AUTO_PAUSED, 3=STOPPED
- running  out  1  high when state==RUNNING
- overflow  out  1  sticky; set when trip time saturates

Behaviour:
- Reset, and clear in any state: state=IDLE; trip_time=0; trip_half_sec=0; overflow=0; running=0; idle counter=0; half-second phase bit=0.
- All outputs are registered. Every change is visible the cycle after the causing input.
- State transitions:
  - IDLE: start_stop -> RUNNING.
  - RUNNING: start_stop -> STOPPED; idle counter reaches AUTO_PAUSE_HS -> AUTO_PAUSED.
  - AUTO_PAUSED: motion_pulse -> RUNNING; start_stop -> STOPPED (start_stop wins over a same-cycle motion_pulse).
  - STOPPED: start_stop -> RUNNING. motion_pulse is ignored in IDLE and STOPPED.
- Priority: reset > clear > start_stop > auto-pause/motion.
- Counting:
  - A half_sec_pulse is counted only when the current (pre-transition) state is RUNNING. Example: a pulse coinciding with start_stop in RUNNING is counted; a pulse coinciding with start_stop in IDLE is not.
  - A counted pulse increments trip_half_sec (saturating at 2^19-1) and toggles the phase bit.
  - On the phase 1->0 toggle, sec increments with a same-cycle carry chain: sec 59->0 carries to min; min 59->0 carries to hrs.
  - At MAX_HRS:59:59 a further carry holds trip_time unchanged and sets overflow. trip_half_sec keeps counting until its own saturation.
- Idle counter (8 bits):
  - Cleared on entry to RUNNING and on motion_pulse in RUNNING.
  - Otherwise incremented by each half_sec_pulse in RUNNING.
  - motion_pulse beats a same-cycle half_sec_pulse: counter goes to 0.
  - The pulse that brings the counter to AUTO_PAUSE_HS is itself counted, and state is AUTO_PAUSED on the next cycle.
- STOPPED and AUTO_PAUSED hold trip_time. The phase bit is preserved across pauses, so no half-second is lost.

Optional Feature:
- Macro: TRIP_AUTO_PAUSE_EN.
- Defined: idle counter and the AUTO_PAUSED state are present; behaviour as above.
- Undefined: the idle counter is removed; AUTO_PAUSED is unreachable; motion_pulse is ignored; state never reads 2. All other behaviour is identical.

Decomposition:
- Package trip_timer_pkg:
  - state enum type, with the encodings above.
  - width constants HRS_W=7, MIN_W=6, SEC_W=7, HMS_W=20, HS_CUM_W=19.
  - SEC_MAX=59, MIN_MAX=59.
- Sub-module hms_counter:
  - Enable-driven, saturating sec/min/hrs carry chain.
  - Inputs: clear and inc; parameter MAX_HRS.
  - Outputs: packed HMS and sat.
- The controller owns the FSM, phase bit, idle counter and trip_half_sec.

Test Plan:
- Reset, then start_stop, then 10 half_sec_pulses -> trip_time=0:0:5; trip_half_sec=10; state=1.
- RUNNING at 0:0:59 with phase=1, then one pulse -> next cycle trip_time=0:1:0. Preload to 0:59:59 -> 1:0:0.
- start_stop and half_sec_pulse in the same cycle from RUNNING -> pulse counted, state=3. From STOPPED -> pulse not counted, state=1.
- TRIP_AUTO_PAUSE_EN defined, AUTO_PAUSE_HS=6, no motion:
  - 6 pulses -> trip_half_sec=6, state=2.
  - Further pulses -> no change.
  - motion_pulse -> state=1, idle counter=0.
  - motion_pulse and half_sec_pulse in the same cycle -> no pause after 6 further pulses counted from that point.
- MAX_HRS=1, run to 1:59:59 with phase=1, then one pulse -> trip_time holds, overflow=1, trip_half_sec still increments.
- clear and start_stop together mid-RUNNING -> state=0; all outputs 0.
- reset asserted mid-count -> same result on the next clock.
